// File: rtl/flash_arbiter.sv
// rtl/flash_arbiter.sv - two-port round-robin command arbiter in front of a flash controller
//
// Purpose: accepts read/write commands from two requesters, forwards one at a
// time to the flash controller as single-cycle f_read/f_write pulses, waits for
// the controller to go busy and idle again, then reports completion to the
// granted requester. A start timeout covers a controller that never goes busy.
//
// Ports:
//   clk, reset                  clock, asynchronous active-low reset
//   mX_req/we/addr/wdata        requester X command (X = 0, 1)
//   mX_gnt, mX_done             one-cycle accept / finish pulses for requester X
//   err                         one-cycle pulse alongside done when the command timed out
//   rdata                       last successfully read byte
//   busy                        high while a command is in flight
//   f_read, f_write             one-cycle command pulses to the flash controller
//   f_addr, f_din               command address / write byte to the flash controller
//   f_dout, f_busy              read byte and busy flag from the flash controller
module flash_arbiter #(
  parameter int unsigned START_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [15:0] m0_addr,
  input  logic [7:0]  m0_wdata,
  output logic        m0_gnt,
  output logic        m0_done,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [15:0] m1_addr,
  input  logic [7:0]  m1_wdata,
  output logic        m1_gnt,
  output logic        m1_done,
  output logic        err,
  output logic [7:0]  rdata,
  output logic        busy,
  output logic        f_read,
  output logic        f_write,
  output logic [15:0] f_addr,
  output logic [7:0]  f_din,
  input  logic [7:0]  f_dout,
  input  logic        f_busy
);

  localparam int unsigned CW = (START_TIMEOUT < 1) ? 1 : $clog2(START_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE, RESP} state_t;

  state_t        state, state_nx;
  logic          last, last_nx;      // port granted most recently (1 = m1)
  logic          owner, owner_nx;    // port owning the command in flight
  logic          dir_we, dir_we_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          tflag, tflag_nx;

  logic          m0_gnt_nx, m1_gnt_nx, m0_done_nx, m1_done_nx, err_nx;
  logic          busy_nx, f_read_nx, f_write_nx;
  logic [7:0]    rdata_nx, f_din_nx;
  logic [15:0]   f_addr_nx;

  // Winner of this cycle's arbitration: m1 when it asks alone, or on a tie
  // when m0 was the last port served.
  logic          win;
  logic          sel_we;
  logic [15:0]   sel_addr;
  logic [7:0]    sel_wdata;

  assign win       = m1_req & (~m0_req | ~last);
  assign sel_we    = win ? m1_we    : m0_we;
  assign sel_addr  = win ? m1_addr  : m0_addr;
  assign sel_wdata = win ? m1_wdata : m0_wdata;

  always_comb begin
    state_nx   = state;
    last_nx    = last;
    owner_nx   = owner;
    dir_we_nx  = dir_we;
    cnt_nx     = cnt;
    tflag_nx   = tflag;
    m0_gnt_nx  = 1'b0;
    m1_gnt_nx  = 1'b0;
    m0_done_nx = 1'b0;
    m1_done_nx = 1'b0;
    err_nx     = 1'b0;
    f_read_nx  = 1'b0;
    f_write_nx = 1'b0;
    rdata_nx   = rdata;
    f_addr_nx  = f_addr;
    f_din_nx   = f_din;

    case (state)
      IDLE: begin
        if (!f_busy && (m0_req || m1_req)) begin
          owner_nx   = win;
          dir_we_nx  = sel_we;
          f_addr_nx  = sel_addr;
          f_din_nx   = sel_wdata;
          m0_gnt_nx  = ~win;
          m1_gnt_nx  = win;
          f_read_nx  = ~sel_we;
          f_write_nx = sel_we;
          cnt_nx     = CW'(START_TIMEOUT);
          state_nx   = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (f_busy) begin
          state_nx = WAIT_DONE;
        end else if (cnt == '0) begin
          tflag_nx = 1'b1;
          state_nx = RESP;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!f_busy) begin
          if (!dir_we) rdata_nx = f_dout;
          state_nx = RESP;
        end
      end
      RESP: begin
        // Done is registered here, so it shows on the first IDLE cycle.
        m0_done_nx = ~owner;
        m1_done_nx = owner;
        err_nx     = tflag;
        last_nx    = owner;
        tflag_nx   = 1'b0;
        state_nx   = IDLE;
      end
      default: state_nx = IDLE;
    endcase

    busy_nx = (state_nx != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      last    <= 1'b1;
      owner   <= 1'b0;
      dir_we  <= 1'b0;
      cnt     <= '0;
      tflag   <= 1'b0;
      m0_gnt  <= 1'b0;
      m1_gnt  <= 1'b0;
      m0_done <= 1'b0;
      m1_done <= 1'b0;
      err     <= 1'b0;
      busy    <= 1'b0;
      f_read  <= 1'b0;
      f_write <= 1'b0;
      rdata   <= '0;
      f_addr  <= '0;
      f_din   <= '0;
    end else begin
      state   <= state_nx;
      last    <= last_nx;
      owner   <= owner_nx;
      dir_we  <= dir_we_nx;
      cnt     <= cnt_nx;
      tflag   <= tflag_nx;
      m0_gnt  <= m0_gnt_nx;
      m1_gnt  <= m1_gnt_nx;
      m0_done <= m0_done_nx;
      m1_done <= m1_done_nx;
      err     <= err_nx;
      busy    <= busy_nx;
      f_read  <= f_read_nx;
      f_write <= f_write_nx;
      rdata   <= rdata_nx;
      f_addr  <= f_addr_nx;
      f_din   <= f_din_nx;
    end
  end

endmodule

// File: tb/tb_flash_arbiter.sv
// tb/tb_flash_arbiter.sv - directed self-checking bench for flash_arbiter
module tb_flash_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [15:0] m0_addr, m1_addr;
  logic [7:0]  m0_wdata, m1_wdata;
  logic        m0_gnt, m0_done, m1_gnt, m1_done;
  logic        err, busy, f_read, f_write;
  logic [7:0]  rdata, f_din, f_dout;
  logic [15:0] f_addr;
  logic        f_busy;

  // Flash controller model: goes busy the cycle after a command pulse and
  // stays busy for 20 cycles, unless model_off; ext_busy forces busy.
  logic        model_busy = 1'b0;
  int          mcnt = 0;
  logic        model_off = 1'b0;
  logic        ext_busy = 1'b0;

  assign f_busy = model_busy | ext_busy;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mcnt > 0) begin
      mcnt <= mcnt - 1;
      if (mcnt == 1) model_busy <= 1'b0;
    end else if ((f_read || f_write) && !model_off) begin
      model_busy <= 1'b1;
      mcnt       <= 20;
    end
  end

  flash_arbiter #(.START_TIMEOUT(15)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_done(m0_done),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_done(m1_done),
    .err(err), .rdata(rdata), .busy(busy),
    .f_read(f_read), .f_write(f_write), .f_addr(f_addr), .f_din(f_din),
    .f_dout(f_dout), .f_busy(f_busy)
  );

  int   n_err = 0;
  int   n_checks = 0;
  int   n, cnt_a, cnt_b, ng, outst, viol;
  logic seq [4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic sig(input int which);
    case (which)
      0: return m0_gnt;
      1: return m1_gnt;
      2: return m0_done;
      default: return m1_done;
    endcase
  endfunction

  // Advance until the selected pulse is seen or the budget runs out;
  // n returns the number of cycles waited.
  task automatic wait_for(input string tag, input int which, input int budget, output int cyc);
    cyc = 0;
    while (!sig(which) && cyc < budget) begin
      tick();
      cyc++;
    end
    chk({tag, "_seen"}, 32'(sig(which)), 32'd1);
  endtask

  initial begin
    reset = 1'b0;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
    f_dout = 8'h55;
    tick(); tick();

    // Reset state
    chk("rst_busy",   32'(busy),   32'd0);
    chk("rst_gnt",    32'({m0_gnt, m1_gnt, m0_done, m1_done, err}), 32'd0);
    chk("rst_fcmd",   32'({f_read, f_write}), 32'd0);
    chk("rst_f_addr", 32'(f_addr), 32'd0);
    chk("rst_f_din",  32'(f_din),  32'd0);
    chk("rst_rdata",  32'(rdata),  32'd0);
    reset = 1'b1;
    tick();

    // m0 read of 0x01AA, flash busy for 20 cycles returning 0x55
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 16'h01AA;
    wait_for("rd_gnt", 0, 10, n);
    chk("rd_gnt_lat", 32'(n), 32'd1);
    chk("rd_f_read",  32'({f_read, f_write}), 32'b10);
    chk("rd_f_addr",  32'(f_addr), 32'h01AA);
    chk("rd_busy",    32'(busy), 32'd1);
    chk("rd_m1_gnt",  32'(m1_gnt), 32'd0);
    m0_req = 1'b0;
    cnt_a = 0; n = 0;
    while (!m0_done && n < 60) begin
      tick(); n++;
      if (f_read || f_write || m0_gnt || m1_gnt) cnt_a++;
    end
    chk("rd_done_seen", 32'(m0_done), 32'd1);
    chk("rd_latency",   32'(n), 32'd23);
    chk("rd_extra_pls", 32'(cnt_a), 32'd0);
    chk("rd_rdata",     32'(rdata), 32'h55);
    chk("rd_err",       32'(err), 32'd0);
    chk("rd_busy_end",  32'(busy), 32'd0);
    tick();
    chk("rd_done_1cyc", 32'(m0_done), 32'd0);

    // m1 write 0x1234 <- 0xA5; input data changes after grant must not leak
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 16'h1234; m1_wdata = 8'hA5;
    wait_for("wr_gnt", 1, 10, n);
    chk("wr_f_write", 32'({f_read, f_write}), 32'b01);
    chk("wr_f_din",   32'(f_din), 32'hA5);
    chk("wr_f_addr",  32'(f_addr), 32'h1234);
    m1_req = 1'b0; m1_wdata = 8'h00; m1_addr = 16'h0000; f_dout = 8'h77;
    cnt_a = 0; cnt_b = 0; n = 0;
    while (!m1_done && n < 60) begin
      tick(); n++;
      if (f_read || f_write) cnt_a++;
      if (f_din !== 8'hA5 || f_addr !== 16'h1234) cnt_b++;
    end
    chk("wr_done_seen", 32'(m1_done), 32'd1);
    chk("wr_extra_pls", 32'(cnt_a), 32'd0);
    chk("wr_stable",    32'(cnt_b), 32'd0);
    chk("wr_rdata",     32'(rdata), 32'h55);
    chk("wr_err",       32'(err), 32'd0);

    // Both ports request continuously after a fresh reset: m0, m1, m0, m1
    reset = 1'b0; tick(); tick(); reset = 1'b1; tick();
    f_dout = 8'h3C;
    m0_we = 1'b0; m1_we = 1'b0; m0_addr = 16'h0100; m1_addr = 16'h0200;
    m0_req = 1'b1; m1_req = 1'b1;
    ng = 0; outst = 0; viol = 0; n = 0;
    while (ng < 4 && n < 400) begin
      tick(); n++;
      if (m0_done || m1_done) outst--;
      if (m0_gnt && m1_gnt) viol++;
      if (m0_gnt || m1_gnt) begin
        if (outst != 0) viol++;
        outst++;
        seq[ng] = m1_gnt;
        ng++;
      end
    end
    m0_req = 1'b0; m1_req = 1'b0;
    chk("rr_count", 32'(ng), 32'd4);
    chk("rr_g0", 32'(seq[0]), 32'd0);
    chk("rr_g1", 32'(seq[1]), 32'd1);
    chk("rr_g2", 32'(seq[2]), 32'd0);
    chk("rr_g3", 32'(seq[3]), 32'd1);
    chk("rr_g3_addr", 32'(f_addr), 32'h0200);
    wait_for("rr_done", 3, 40, n);
    chk("rr_overlap", 32'(viol), 32'd0);
    chk("rr_rdata",   32'(rdata), 32'h3C);

    // Flash never goes busy: 16 cycles in WAIT_BUSY, then done + err
    model_off = 1'b1;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 16'h0BAD;
    wait_for("to_gnt", 0, 10, n);
    m0_req = 1'b0;
    wait_for("to_done", 2, 40, n);
    chk("to_latency", 32'(n), 32'd17);
    chk("to_err",     32'(err), 32'd1);
    chk("to_rdata",   32'(rdata), 32'h3C);
    tick();
    chk("to_err_1cyc", 32'({err, m0_done}), 32'd0);
    model_off = 1'b0;
    f_dout = 8'h96;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 16'h0042;
    wait_for("to_next_gnt", 1, 10, n);
    m1_req = 1'b0;
    wait_for("to_next_done", 3, 40, n);
    chk("to_next_lat",   32'(n), 32'd23);
    chk("to_next_err",   32'(err), 32'd0);
    chk("to_next_rdata", 32'(rdata), 32'h96);

    // External f_busy holds off the grant until it falls
    ext_busy = 1'b1;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 16'h2222;
    cnt_a = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (m0_gnt || m1_gnt || busy) cnt_a++;
    end
    chk("fb_hold", 32'(cnt_a), 32'd0);
    ext_busy = 1'b0;
    tick();
    chk("fb_gnt",    32'(m0_gnt), 32'd1);
    chk("fb_f_addr", 32'(f_addr), 32'h2222);
    m0_req = 1'b0;
    wait_for("fb_done", 2, 40, n);

    // Reset during WAIT_DONE aborts silently; m1 read then completes
    f_dout = 8'hC3;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 16'h0777;
    wait_for("ar_gnt", 0, 10, n);
    m0_req = 1'b0;
    tick(); tick(); tick(); tick();
    chk("ar_in_flight", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    chk("ar_busy",   32'(busy), 32'd0);
    chk("ar_f_addr", 32'(f_addr), 32'd0);
    chk("ar_rdata",  32'(rdata), 32'd0);
    chk("ar_pulses", 32'({m0_gnt, m1_gnt, m0_done, m1_done, err, f_read, f_write}), 32'd0);
    cnt_a = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (m0_done || m1_done || err || busy) cnt_a++;
    end
    reset = 1'b1;
    f_dout = 8'h5A;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 16'h0F0F;
    for (int i = 0; i < 30; i++) begin
      if (!m1_gnt) begin
        tick();
        if (m0_done || m1_done || err) cnt_a++;
      end
    end
    chk("ar_no_done", 32'(cnt_a), 32'd0);
    chk("ar_m1_gnt",  32'(m1_gnt), 32'd1);
    chk("ar_m1_addr", 32'(f_addr), 32'h0F0F);
    m1_req = 1'b0;
    wait_for("ar_m1_done", 3, 40, n);
    chk("ar_m1_err",   32'(err), 32'd0);
    chk("ar_m1_rdata", 32'(rdata), 32'h5A);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
